// File: rtl/kws_wb_ctrl.sv
// kws_wb_ctrl: Wishbone register front-end for the KWS core.
//   Provides start/opcode control, status, a feature FIFO streaming to CMVN,
//   result capture and three registered level interrupts.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   wbs_*                   Wishbone classic slave (adr[4:2] decoded)
//   kws_start/kws_opcode    start pulse and opcode to kws_fsm
//   kws_done                completion from kws_fsm (honoured only in RUN)
//   feat_data/addr/valid    FIFO head, feature index, FIFO not empty
//   feat_ready              CMVN accepts the head this cycle
//   res_data/res_valid      result word and capture strobe
//   irq[2:0]                {res_pending, overflow, done} gated by irq_en
//
// FSM states
//   state | meaning
//   IDLE  | waiting for a CTRL write with start=1
//   START | kws_start asserted for one cycle
//   RUN   | waiting for kws_done
module kws_wb_ctrl #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int FEAT_N     = 32,
    parameter int ADDR_W     = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              kws_start,
    output logic [3:0]        kws_opcode,
    input  logic              kws_done,
    output logic [DATA_W-1:0] feat_data,
    output logic [ADDR_W-1:0] feat_addr,
    output logic              feat_valid,
    input  logic              feat_ready,
    input  logic [DATA_W-1:0] res_data,
    input  logic              res_valid,
    output logic [2:0]        irq
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, START, RUN} state_t;

    state_t state, next_state;

    logic [2:0]        irq_en;
    logic              done, overflow, res_pending;
    logic [DATA_W-1:0] res_q;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [31:0]       rdata;

    logic wb_req, wr, rd;
    logic wr_ctrl, wr_feat, wr_irqclr, rd_result;
    logic start_req, clr_req, push_req, pop, fifo_full, do_push, drop, run_done;
    logic unused_ok;

    // Request is taken only while ack is low, so each access costs two cycles.
    assign wb_req    = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign wr        = wb_req & wbs_we_i;
    assign rd        = wb_req & ~wbs_we_i;
    assign wr_ctrl   = wr & (wbs_adr_i[4:2] == 3'd0);
    assign wr_feat   = wr & (wbs_adr_i[4:2] == 3'd2);
    assign rd_result = rd & (wbs_adr_i[4:2] == 3'd3);
    assign wr_irqclr = wr & (wbs_adr_i[4:2] == 3'd4);

    assign start_req = wr_ctrl & wbs_sel_i[0] & wbs_dat_i[0] & (state == IDLE);
    assign clr_req   = wr_ctrl & wbs_sel_i[0] & wbs_dat_i[1];
    assign run_done  = (state == RUN) & kws_done;

    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign feat_valid = (count != '0);
    assign feat_data  = mem[rd_ptr];
    assign pop        = feat_valid & feat_ready;
    assign push_req   = wr_feat & (wbs_sel_i == 4'hF);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push    = push_req & ~clr_req & (~fifo_full | pop);
    assign drop       = push_req & ~clr_req & fifo_full & ~pop;

    assign unused_ok = ^{wbs_adr_i, wbs_dat_i};

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        kws_start  = 1'b0;
        case (state)
            IDLE:    if (start_req) next_state = START;
            START: begin
                kws_start  = 1'b1;
                next_state = RUN;
            end
            RUN:     if (kws_done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        rdata = '0;
        case (wbs_adr_i[4:2])
            3'd0:    rdata = {21'b0, irq_en, kws_opcode, 4'b0};
            3'd1:    rdata = {16'b0, 8'(count), 4'b0, res_pending, overflow, done,
                              (state != IDLE)};
            3'd3:    rdata = 32'(res_q);
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= wb_req;
            wbs_dat_o <= rd ? rdata : '0;
        end
    end

    // Control and flags; hardware sets are tested before W1C clears.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            kws_opcode  <= '0;
            irq_en      <= '0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            res_pending <= 1'b0;
            res_q       <= '0;
            irq         <= '0;
        end else begin
            if (wr_ctrl & wbs_sel_i[0] & (state == IDLE)) kws_opcode <= wbs_dat_i[7:4];
            if (wr_ctrl & wbs_sel_i[1])                   irq_en     <= wbs_dat_i[10:8];

            if (run_done)                               done <= 1'b1;
            else if (start_req | (wr_irqclr & wbs_dat_i[0])) done <= 1'b0;

            if (drop)                           overflow <= 1'b1;
            else if (wr_irqclr & wbs_dat_i[1])  overflow <= 1'b0;

            if (res_valid) begin
                res_q       <= res_data;
                res_pending <= 1'b1;
            end else if (rd_result | (wr_irqclr & wbs_dat_i[2])) begin
                res_pending <= 1'b0;
            end

            irq <= {res_pending & irq_en[2], overflow & irq_en[1], done & irq_en[0]};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wbs_dat_i[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            feat_addr <= '0;
        end else if (clr_req) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            feat_addr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push & ~pop)      count <= count + CNT_W'(1);
            else if (pop & ~do_push) count <= count - CNT_W'(1);

            if (start_req)
                feat_addr <= '0;
            else if (pop)
                feat_addr <= (feat_addr == ADDR_W'(FEAT_N - 1)) ? '0 : feat_addr + ADDR_W'(1);
        end
    end

endmodule

// File: tb/tb_kws_wb_ctrl.sv
module tb_kws_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        kws_start;
    logic [3:0]  kws_opcode;
    logic        kws_done;
    logic [31:0] feat_data;
    logic [4:0]  feat_addr;
    logic        feat_valid, feat_ready;
    logic [31:0] res_data;
    logic        res_valid;
    logic [2:0]  irq;

    int errors = 0;
    int checks = 0;
    logic [31:0] rd;

    kws_wb_ctrl #(.DATA_W(32), .FIFO_DEPTH(16), .FEAT_N(32), .ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .kws_start(kws_start), .kws_opcode(kws_opcode), .kws_done(kws_done),
        .feat_data(feat_data), .feat_addr(feat_addr), .feat_valid(feat_valid),
        .feat_ready(feat_ready), .res_data(res_data), .res_valid(res_valid),
        .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] data);
        logic got;
        got = 1'b0;
        @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (wbs_ack_o) begin
                got = 1'b1;
                break;
            end
        end
        data = wbs_dat_o;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        check("wb_ack", {31'b0, got}, 32'd1);
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] dummy;
        wb_xfer(1'b1, adr, dat, sel, dummy);
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] data);
        wb_xfer(1'b0, adr, 32'h0, 4'hF, data);
    endtask

    task automatic pulse_res(input logic [31:0] d);
        @(negedge clk);
        res_valid = 1'b1; res_data = d;
        @(negedge clk);
        res_valid = 1'b0;
    endtask

    task automatic drain(input string tag, input int n, input logic [31:0] d0, input int a0);
        @(negedge clk);
        feat_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            check({tag, "_valid"}, {31'b0, feat_valid}, 32'd1);
            check({tag, "_data"}, feat_data, d0 + 32'(i));
            check({tag, "_addr"}, {27'b0, feat_addr}, 32'((a0 + i) % 32));
            @(posedge clk); #1;
        end
        feat_ready = 1'b0;
        check({tag, "_empty"}, {31'b0, feat_valid}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_sel_i = 4'hF; wbs_adr_i = 32'h4; wbs_dat_i = 32'h0;
        kws_done = 1'b0; feat_ready = 1'b0; res_valid = 1'b0; res_data = 32'h0;

        // Reset with an active request held on the bus
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", {31'b0, wbs_ack_o}, 32'd0);
        check("rst_irq", {29'b0, irq}, 32'd0);
        check("rst_dat", wbs_dat_o, 32'd0);
        check("rst_start", {31'b0, kws_start}, 32'd0);
        check("rst_opcode", {28'b0, kws_opcode}, 32'd0);
        check("rst_fvalid", {31'b0, feat_valid}, 32'd0);
        check("rst_faddr", {27'b0, feat_addr}, 32'd0);
        @(negedge clk);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        rst_n = 1'b1;
        wb_read(32'h04, rd);
        check("rst_status", rd, 32'h0);

        // kws_done outside RUN must not set done
        @(negedge clk); kws_done = 1'b1;
        @(negedge clk); kws_done = 1'b0;
        wb_read(32'h04, rd);
        check("idle_done_ignored", rd, 32'h0);

        // Start handshake
        wb_write(32'h00, 32'h0000_0131, 4'hF);
        check("start_pulse", {31'b0, kws_start}, 32'd1);
        check("start_opcode", {28'b0, kws_opcode}, 32'd3);
        @(posedge clk); #1;
        check("start_one_cycle", {31'b0, kws_start}, 32'd0);
        wb_read(32'h04, rd);
        check("status_busy", rd, 32'h1);

        // Start and opcode while busy are ignored; irq_en still written
        wb_write(32'h00, 32'h0000_0171, 4'hF);
        check("busy_no_start", {31'b0, kws_start}, 32'd0);
        @(posedge clk); #1;
        check("busy_no_start2", {31'b0, kws_start}, 32'd0);
        check("busy_opcode", {28'b0, kws_opcode}, 32'd3);
        wb_read(32'h00, rd);
        check("ctrl_read", rd, 32'h0000_0130);

        @(negedge clk); kws_done = 1'b1;
        @(posedge clk); #1; kws_done = 1'b0;
        check("irq0_latency", {29'b0, irq}, 32'd0);
        @(posedge clk); #1;
        check("irq0_set", {29'b0, irq}, 32'd1);
        wb_read(32'h04, rd);
        check("status_done", rd, 32'h2);
        wb_write(32'h10, 32'h1, 4'hF);
        @(posedge clk); #1;
        check("irq0_clr", {29'b0, irq}, 32'd0);
        wb_read(32'h04, rd);
        check("status_after_clr", rd, 32'h0);

        // Streaming
        for (int i = 0; i < 4; i++) wb_write(32'h08, 32'h11 + 32'(i), 4'hF);
        wb_write(32'h08, 32'hEE, 4'h3);
        wb_read(32'h04, rd);
        check("level4", rd, 32'h0000_0400);
        wb_read(32'h08, rd);
        check("feat_read_zero", rd, 32'h0);
        drain("stream", 4, 32'h11, 0);

        // Overflow
        for (int i = 0; i < 17; i++) wb_write(32'h08, 32'h100 + 32'(i), 4'hF);
        wb_read(32'h04, rd);
        check("ovf_status", rd, 32'h0000_1004);
        check("ovf_irq_masked", {29'b0, irq}, 32'd0);
        drain("ovf", 16, 32'h100, 4);
        for (int i = 0; i < 3; i++) wb_write(32'h08, 32'h500 + 32'(i), 4'hF);
        wb_write(32'h00, 32'h2, 4'h1);
        check("clr_faddr", {27'b0, feat_addr}, 32'd0);
        check("clr_fvalid", {31'b0, feat_valid}, 32'd0);
        wb_read(32'h04, rd);
        check("clr_status", rd, 32'h4);
        wb_write(32'h10, 32'h2, 4'hF);
        wb_read(32'h04, rd);
        check("ovf_cleared", rd, 32'h0);

        // feat_addr wrap over 33 words
        for (int i = 0; i < 16; i++) wb_write(32'h08, 32'h200 + 32'(i), 4'hF);
        drain("wrap_a", 16, 32'h200, 0);
        for (int i = 0; i < 16; i++) wb_write(32'h08, 32'h300 + 32'(i), 4'hF);
        drain("wrap_b", 16, 32'h300, 16);
        wb_write(32'h08, 32'h400, 4'hF);
        drain("wrap_c", 1, 32'h400, 0);

        // Result capture
        pulse_res(32'hDEAD);
        wb_read(32'h04, rd);
        check("res_pending", rd, 32'h8);
        check("res_irq_masked", {29'b0, irq}, 32'd0);
        wb_read(32'h0C, rd);
        check("res_read", rd, 32'hDEAD);
        wb_read(32'h04, rd);
        check("res_cleared", rd, 32'h0);

        pulse_res(32'h1111);
        pulse_res(32'h2222);
        wb_read(32'h0C, rd);
        check("res_overwrite", rd, 32'h2222);

        // New result in the same cycle as a RESULT read
        repeat (2) @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h0C;
        res_valid = 1'b1; res_data = 32'h3333;
        @(posedge clk); #1;
        res_valid = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        check("race_ack", {31'b0, wbs_ack_o}, 32'd1);
        check("race_old", wbs_dat_o, 32'h2222);
        wb_read(32'h04, rd);
        check("race_pending", rd, 32'h8);
        wb_read(32'h0C, rd);
        check("race_new", rd, 32'h3333);

        // irq[2] via irq_en written on byte lane 1 only
        wb_write(32'h00, 32'h0000_0400, 4'h2);
        pulse_res(32'h4444);
        @(posedge clk); #1;
        check("irq2_set", {29'b0, irq}, 32'd4);
        wb_write(32'h10, 32'h4, 4'hF);
        @(posedge clk); #1;
        check("irq2_clr", {29'b0, irq}, 32'd0);

        wb_read(32'h14, rd);
        check("unmapped_read", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
